// File: rtl/ahb_lite_master_if.sv
// ahb_lite_master_if
//   Single-outstanding AHB-lite initiator. One local command becomes one AHB-lite
//   SINGLE transfer, and the block then returns read data and error status to the local side.
//   Misaligned or oversize commands are rejected locally and never reach the bus.
//
// Ports
//   clk_i, rst_i              clock and synchronous active-high reset
//   cmd_valid_i / cmd_ready_o local command handshake
//   cmd_write_i, cmd_addr_i,  command fields, captured on accept
//   cmd_size_i, cmd_wdata_i
//   resp_valid_o              one-cycle completion pulse
//   resp_rdata_o, resp_err_o  valid with resp_valid_o, zero otherwise
//   wait_cnt_o                data-phase hready_i-low cycles of the last transfer, saturating
//   haddr_o .. hwdata_o       AHB-lite master outputs (all registered)
//   hready_i, hresp_i,        AHB-lite slave-side inputs
//   hrdata_i
//   dbg_state_o               current FSM state (IDLE=0, ADDR=1, DATA=2, REJ=3)
//
// Handshake: a command transfers on a rising edge where cmd_valid_i and cmd_ready_o
// are both high. The command fields must be stable while cmd_valid_i is high.
// cmd_ready_o is high only in IDLE and outside reset. A response has no back-pressure.
// resp_valid_o is a single-cycle pulse, and the local side must take it in that cycle.
module ahb_lite_master_if #(
  parameter int WAIT_CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [31:0]           cmd_addr_i,
  input  logic [2:0]            cmd_size_i,
  input  logic [31:0]           cmd_wdata_i,
  output logic                  resp_valid_o,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_err_o,
  output logic [WAIT_CNT_W-1:0] wait_cnt_o,
  output logic [31:0]           haddr_o,
  output logic [1:0]            htrans_o,
  output logic                  hwrite_o,
  output logic [2:0]            hsize_o,
  output logic [2:0]            hburst_o,
  output logic [3:0]            hprot_o,
  output logic                  hmastlock_o,
  output logic [31:0]           hwdata_o,
  input  logic                  hready_i,
  input  logic [1:0]            hresp_i,
  input  logic [31:0]           hrdata_i,
  output logic [1:0]            dbg_state_o
);

  localparam int HADDR_WIDTH = 32;
  localparam int HDATA_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_REJ  = 2'd3
  } state_t;

  state_t state;

  logic cmd_reject;
  logic unused_hresp;

  // hresp_i[1] (RETRY/SPLIT in full AHB) has no meaning on AHB-lite.
  assign unused_hresp = hresp_i[1];

  // Reject a command whose size is above a word, or a command that is not aligned to its own size.
  assign cmd_reject = (cmd_size_i > 3'd2) ||
                      ((cmd_size_i == 3'd1) && cmd_addr_i[0]) ||
                      ((cmd_size_i == 3'd2) && (cmd_addr_i[1:0] != 2'b00));

  assign cmd_ready_o = (state == S_IDLE) && !rst_i;
  assign dbg_state_o = state;

  assign hburst_o    = 3'b000;
  assign hprot_o     = 4'b0011;
  assign hmastlock_o = 1'b0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      htrans_o     <= HTRANS_IDLE;
      haddr_o      <= '0;
      hwrite_o     <= 1'b0;
      hsize_o      <= 3'd0;
      hwdata_o     <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
      wait_cnt_o   <= '0;
    end else begin
      // The response fields are pulses. They are zero in every cycle that is not a completion cycle.
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_rdata_o <= '0;
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            if (cmd_reject) begin
              state <= S_REJ;
            end else begin
              state      <= S_ADDR;
              htrans_o   <= HTRANS_NONSEQ;
              haddr_o    <= cmd_addr_i[HADDR_WIDTH-1:0];
              hwrite_o   <= cmd_write_i;
              hsize_o    <= cmd_size_i;
              // Write data is loaded now and then held through the whole data phase.
              hwdata_o   <= cmd_wdata_i[HDATA_WIDTH-1:0];
              wait_cnt_o <= '0;
            end
          end
        end
        S_ADDR: begin
          // hready_i low here belongs to the previous owner's data phase.
          if (hready_i) begin
            state    <= S_DATA;
            htrans_o <= HTRANS_IDLE;
          end
        end
        S_DATA: begin
          if (hready_i) begin
            state        <= S_IDLE;
            resp_valid_o <= 1'b1;
            resp_err_o   <= hresp_i[0];
            resp_rdata_o <= (!hwrite_o && !hresp_i[0]) ? hrdata_i : '0;
          end else if (wait_cnt_o != '1) begin
            // This also counts the first ERROR cycle. htrans_o is already IDLE, so no cancel is needed.
            wait_cnt_o <= wait_cnt_o + WAIT_CNT_W'(1);
          end
        end
        S_REJ: begin
          state        <= S_IDLE;
          resp_valid_o <= 1'b1;
          resp_err_o   <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
